writeback: RTL and testbench

- Final stage of the 2-slot pipeline. Consumes the memory stage's registered outputs: the instruction pair, upper/lower destination tags, lower-slot ALU data, and the data-RAM read word, which arrives one cycle after the read address.
- Selects the load or ALU result per slot and resolves same-register collisions.
- Drives both register-file write ports through a one-cycle output register.
- Also keeps a retired-instruction counter and detects HALT.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/wb_slot_sel.sv | 39 +++
 rtl/writeback.sv | 104 ++++++++++
 tb/tb_writeback.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, widths and writeback state type
package cpu_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_LOAD  = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b010001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [DATA_W-1:0] BUBBLE_INST = 32'hE000_0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_slot_sel.sv
// rtl/wb_slot_sel.sv - per-slot result mux, r0 gating and bubble/halt decode
module wb_slot_sel
    import cpu_pkg::*;
#(
    // 1 for the lower slot, which may write ALU results; 0 for the load-only upper slot
    parameter bit ALU_WRITE = 1'b1
) (
    input  logic [DATA_W-1:0] slot,
    input  logic [REG_W-1:0]  rt,
    input  logic              rt_flag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic              we,
    output logic [DATA_W-1:0] wdata,
    output logic              is_bubble,
    output logic              is_halt,
    output logic              illegal
);

    logic [5:0] opcode;
    logic       is_load;
    logic       is_store;

    always_comb begin
        opcode    = slot[31:26];
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_halt   = (opcode == OP_HALT);
        is_bubble = (slot == BUBBLE_INST);

        wdata = is_load ? mem_data : (ALU_WRITE ? alu_data : '0);

        we = rt_flag && !is_bubble && !is_store && !is_halt
             && (rt != '0) && (is_load || ALU_WRITE);

        illegal = rt_flag && !is_bubble && !is_load && !ALU_WRITE;
    end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - final pipeline stage: register-file write ports, retire counter, HALT
module writeback
    import cpu_pkg::*;
#(
    parameter int CNT_W = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interlock,
    input  logic [63:0]          inst,
    input  logic [REG_W-1:0]     u_rt,
    input  logic                 u_rt_flag,
    input  logic [DATA_W-1:0]    l_tdata,
    input  logic [REG_W-1:0]     l_rt,
    input  logic                 l_rt_flag,
    input  logic [63:0]          mem_doutb,
    output logic                 u_we,
    output logic [REG_W-1:0]     u_waddr,
    output logic [DATA_W-1:0]    u_wdata,
    output logic                 l_we,
    output logic [REG_W-1:0]     l_waddr,
    output logic [DATA_W-1:0]    l_wdata,
    output logic [CNT_W-1:0]     retired,
    output logic                 halted
);

    wb_state_t         state;
    logic              u_we_s, l_we_s;
    logic [DATA_W-1:0] u_data_s, l_data_s;
    logic              u_bubble, l_bubble;
    logic              u_halt, l_halt;
    logic              u_illegal, l_illegal_unused;

    logic accept, u_ret, l_ret, collide, u_we_nxt, l_we_nxt, halt_acc;

    wb_slot_sel #(.ALU_WRITE(1'b0)) u_sel (
        .slot      (inst[63:32]),
        .rt        (u_rt),
        .rt_flag   (u_rt_flag),
        .alu_data  ('0),
        .mem_data  (mem_doutb[63:32]),
        .we        (u_we_s),
        .wdata     (u_data_s),
        .is_bubble (u_bubble),
        .is_halt   (u_halt),
        .illegal   (u_illegal)
    );

    wb_slot_sel #(.ALU_WRITE(1'b1)) l_sel (
        .slot      (inst[31:0]),
        .rt        (l_rt),
        .rt_flag   (l_rt_flag),
        .alu_data  (l_tdata),
        .mem_data  (mem_doutb[31:0]),
        .we        (l_we_s),
        .wdata     (l_data_s),
        .is_bubble (l_bubble),
        .is_halt   (l_halt),
        .illegal   (l_illegal_unused)
    );

    // Upper HALT still lets the lower slot retire: HALT marks a pair boundary
    always_comb begin
        accept   = !interlock && (state == RUN);
        u_ret    = accept && !u_bubble;
        l_ret    = accept && !l_bubble;
        collide  = u_rt_flag && l_rt_flag && (u_rt == l_rt);
        u_we_nxt = u_ret && u_we_s && !collide;
        l_we_nxt = l_ret && l_we_s;
        halt_acc = (u_ret && u_halt) || (l_ret && l_halt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            u_we    <= 1'b0;
            u_waddr <= '0;
            u_wdata <= '0;
            l_we    <= 1'b0;
            l_waddr <= '0;
            l_wdata <= '0;
            retired <= '0;
        end else begin
            u_we <= u_we_nxt;
            l_we <= l_we_nxt;
            if (u_we_nxt) begin
                u_waddr <= u_rt;
                u_wdata <= u_data_s;
            end
            if (l_we_nxt) begin
                l_waddr <= l_rt;
                l_wdata <= l_data_s;
            end
            retired <= retired + CNT_W'(u_ret) + CNT_W'(l_ret);
            if (halt_acc)
                state <= HALTED;
        end
    end

    assign halted = (state == HALTED);

    upper_nonload_write: assert property (@(posedge clk) disable iff (rst) !(accept && u_illegal));

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed self-checking bench for writeback
module tb_writeback;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        interlock;
    logic [63:0] inst;
    logic [4:0]  u_rt, l_rt;
    logic        u_rt_flag, l_rt_flag;
    logic [31:0] l_tdata;
    logic [63:0] mem_doutb;

    logic        u_we, l_we, halted;
    logic [4:0]  u_waddr, l_waddr;
    logic [31:0] u_wdata, l_wdata;
    logic [47:0] retired;

    logic        u_we_n, l_we_n, halted_n;
    logic [4:0]  u_waddr_n, l_waddr_n;
    logic [31:0] u_wdata_n, l_wdata_n;
    logic [3:0]  retired_n;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;
    logic [3:0] exp_ret4;

    localparam logic [31:0] ALU   = 32'h0000_0000;
    localparam logic [31:0] LOAD  = 32'h4000_0000;
    localparam logic [31:0] STORE = 32'h4400_0000;
    localparam logic [31:0] HALT  = 32'hFC00_0000;
    localparam logic [31:0] BUB   = 32'hE000_0000;

    always #5 clk = ~clk;

    writeback dut (
        .clk(clk), .rst(rst), .interlock(interlock), .inst(inst),
        .u_rt(u_rt), .u_rt_flag(u_rt_flag), .l_tdata(l_tdata),
        .l_rt(l_rt), .l_rt_flag(l_rt_flag), .mem_doutb(mem_doutb),
        .u_we(u_we), .u_waddr(u_waddr), .u_wdata(u_wdata),
        .l_we(l_we), .l_waddr(l_waddr), .l_wdata(l_wdata),
        .retired(retired), .halted(halted)
    );

    writeback #(.CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .interlock(interlock), .inst(inst),
        .u_rt(u_rt), .u_rt_flag(u_rt_flag), .l_tdata(l_tdata),
        .l_rt(l_rt), .l_rt_flag(l_rt_flag), .mem_doutb(mem_doutb),
        .u_we(u_we_n), .u_waddr(u_waddr_n), .u_wdata(u_wdata_n),
        .l_we(l_we_n), .l_waddr(l_waddr_n), .l_wdata(l_wdata_n),
        .retired(retired_n), .halted(halted_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ui, input logic [31:0] li,
                         input logic uf, input logic [4:0] ur,
                         input logic lf, input logic [4:0] lr,
                         input logic [31:0] td, input logic [63:0] md);
        inst = {ui, li};
        u_rt_flag = uf; u_rt = ur;
        l_rt_flag = lf; l_rt = lr;
        l_tdata = td;   mem_doutb = md;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ret(input string tag);
        exp_ret4 = exp_ret[3:0];
        check(tag, {16'h0, retired}, 64'(exp_ret));
        check({tag, "_w4"}, {60'h0, retired_n}, {60'h0, exp_ret4});
    endtask

    initial begin
        rst = 1'b1; interlock = 1'b0;
        @(negedge clk);
        drive(BUB, BUB, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 64'h0);
        check("rst_u_we", {63'h0, u_we}, 64'h0);
        check("rst_l_we", {63'h0, l_we}, 64'h0);
        check("rst_waddr", {54'h0, u_waddr, l_waddr}, 64'h0);
        check("rst_wdata", {u_wdata, l_wdata}, 64'h0);
        check_ret("rst_retired");
        check("rst_halted", {63'h0, halted}, 64'h0);
        rst = 1'b0;

        // lower ALU write, upper bubble
        drive(BUB, ALU, 1'b0, 5'd0, 1'b1, 5'd3, 32'h1234, 64'h0);
        exp_ret = 1;
        check("alu_u_we", {63'h0, u_we}, 64'h0);
        check("alu_l_we", {63'h0, l_we}, 64'h1);
        check("alu_l_waddr", {59'h0, l_waddr}, 64'd3);
        check("alu_l_wdata", {32'h0, l_wdata}, 64'h1234);
        check_ret("alu_retired");

        // dual load
        drive(LOAD, LOAD, 1'b1, 5'd4, 1'b1, 5'd5, 32'hDEAD, 64'hAAAA_0001_BBBB_0002);
        exp_ret = 3;
        check("ld_we", {62'h0, u_we, l_we}, 64'h3);
        check("ld_u", {27'h0, u_waddr, u_wdata}, {27'h0, 5'd4, 32'hAAAA_0001});
        check("ld_l", {27'h0, l_waddr, l_wdata}, {27'h0, 5'd5, 32'hBBBB_0002});
        check_ret("ld_retired");

        // collision: lower wins, upper address/data hold
        drive(LOAD, LOAD, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0, 64'h1111_2222_3333_4444);
        exp_ret = 5;
        check("col_we", {62'h0, u_we, l_we}, 64'h1);
        check("col_u_hold", {27'h0, u_waddr, u_wdata}, {27'h0, 5'd4, 32'hAAAA_0001});
        check("col_l", {27'h0, l_waddr, l_wdata}, {27'h0, 5'd7, 32'h3333_4444});
        check_ret("col_retired");

        // r0 write suppressed
        drive(BUB, ALU, 1'b0, 5'd0, 1'b1, 5'd0, 32'h9999, 64'h0);
        exp_ret = 6;
        check("r0_l_we", {63'h0, l_we}, 64'h0);
        check("r0_l_hold", {27'h0, l_waddr, l_wdata}, {27'h0, 5'd7, 32'h3333_4444});
        check_ret("r0_retired");

        // interlock bubbles both slots
        interlock = 1'b1;
        drive(LOAD, LOAD, 1'b1, 5'd10, 1'b1, 5'd11, 32'h0, 64'h5555_5555_6666_6666);
        interlock = 1'b0;
        check("ilk_we", {62'h0, u_we, l_we}, 64'h0);
        check_ret("ilk_retired");

        // upper STORE retires without writing, lower ALU writes
        drive(STORE, ALU, 1'b0, 5'd0, 1'b1, 5'd9, 32'h55, 64'h0);
        exp_ret = 8;
        check("st_we", {62'h0, u_we, l_we}, 64'h1);
        check("st_l", {27'h0, l_waddr, l_wdata}, {27'h0, 5'd9, 32'h55});
        check_ret("st_retired");

        // lower STORE with flag still never writes
        drive(BUB, STORE, 1'b0, 5'd0, 1'b1, 5'd12, 32'h77, 64'h0);
        exp_ret = 9;
        check("lst_l_we", {63'h0, l_we}, 64'h0);
        check_ret("lst_retired");

        // upper HALT, lower ALU still retires
        drive(HALT, ALU, 1'b0, 5'd0, 1'b1, 5'd2, 32'hCAFE, 64'h0);
        exp_ret = 11;
        check("halt_l", {26'h0, l_we, l_waddr, l_wdata}, {26'h0, 1'b1, 5'd2, 32'hCAFE});
        check("halt_flag", {63'h0, halted}, 64'h1);
        check_ret("halt_retired");

        // frozen while halted
        drive(LOAD, LOAD, 1'b1, 5'd13, 1'b1, 5'd14, 32'h0, 64'h1_0000_0002);
        drive(BUB, ALU, 1'b0, 5'd0, 1'b1, 5'd15, 32'h88, 64'h0);
        check("frz_we", {62'h0, u_we, l_we}, 64'h0);
        check("frz_l_hold", {27'h0, l_waddr, l_wdata}, {27'h0, 5'd2, 32'hCAFE});
        check("frz_halted", {63'h0, halted}, 64'h1);
        check_ret("frz_retired");

        // reset exits HALTED
        rst = 1'b1;
        drive(LOAD, LOAD, 1'b1, 5'd13, 1'b1, 5'd14, 32'h0, 64'h0);
        rst = 1'b0;
        exp_ret = 0;
        check("rst2_halted", {63'h0, halted}, 64'h0);
        check("rst2_we", {62'h0, u_we, l_we}, 64'h0);
        check_ret("rst2_retired");

        // HALT under interlock is not accepted
        interlock = 1'b1;
        drive(HALT, HALT, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 64'h0);
        interlock = 1'b0;
        check("ilk_halt", {63'h0, halted}, 64'h0);
        check_ret("ilk_halt_retired");

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 7; i++)
            drive(LOAD, LOAD, 1'b1, 5'd20, 1'b1, 5'd21, 32'h0, 64'(i));
        exp_ret = 14;
        check_ret("wrap_14");
        drive(LOAD, LOAD, 1'b1, 5'd20, 1'b1, 5'd21, 32'h0, 64'h0);
        exp_ret = 16;
        check_ret("wrap_16");
        check("wrap_n_zero", {60'h0, retired_n}, 64'h0);

        // lower HALT also halts and counts
        drive(BUB, HALT, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 64'h0);
        exp_ret = 17;
        check("lhalt_flag", {63'h0, halted}, 64'h1);
        check_ret("lhalt_retired");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
